// File: rtl/switch_debounce_event.sv
// ---------------------------------------------------------------------------
// switch_debounce_event
//   Front end for the board slide switches. Each switch is synchronised,
//   debounced and turned into a clean level, a one-cycle-delayed history
//   copy, and registered rise/fall pulses. Every accepted edge is also
//   queued as an ordered event (switch index + direction) in a small FIFO
//   with a valid/ready handshake. Simultaneous edges are serialised in
//   ascending index order, one per cycle. When an event is overwritten
//   before it reaches the FIFO, a sticky flag is raised.
//
//   Ports
//     CLK, RESET_N  system clock; asynchronous active-low reset
//     SW_RAW        raw switch pins, asynchronous to CLK
//     SW_CLEAN      debounced switch levels
//     SW_HISTORY    SW_CLEAN delayed one cycle
//     SW_RISE/FALL  one-cycle pulses in the cycle SW_CLEAN changes
//     EVT_VALID     FIFO head holds an event
//     EVT_IDX       head switch index (4'hF when empty)
//     EVT_UP        head direction, 1 = rise (0 when empty)
//     EVT_READY     consumer accepts the head when EVT_VALID & EVT_READY
//     OVERFLOW      sticky: a pending event was overwritten
// ---------------------------------------------------------------------------

// Per-switch synchroniser and debouncer.
//   raw_i    raw pin
//   clean_o  debounced level;  hist_o  clean_o delayed one cycle
//   rise_o / fall_o  registered edge pulses
//   acc_o    combinational: a new level is being accepted this cycle
//   acc_up_o direction of that accepted level (the synchronised sample)
module switch_debounce_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic raw_i,
    output logic clean_o,
    output logic hist_o,
    output logic rise_o,
    output logic fall_o,
    output logic acc_o,
    output logic acc_up_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   hist_q;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   acc;

    assign s = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronised sample disagrees with
    // the clean level; any agreeing sample restarts the window.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        acc     = 1'b0;
        if (s != clean_q) begin
            if (cnt_q >= CNT_MAX) begin
                acc     = 1'b1;
                clean_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            hist_q  <= clean_q;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o  = clean_q;
    assign hist_o   = hist_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign acc_o    = acc;
    assign acc_up_o = s;
endmodule

module switch_debounce_event #(
    parameter int N_SW            = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [N_SW-1:0] SW_RAW,
    output logic [N_SW-1:0] SW_CLEAN,
    output logic [N_SW-1:0] SW_HISTORY,
    output logic [N_SW-1:0] SW_RISE,
    output logic [N_SW-1:0] SW_FALL,
    output logic            EVT_VALID,
    output logic [3:0]      EVT_IDX,
    output logic            EVT_UP,
    input  logic            EVT_READY,
    output logic            OVERFLOW
);
    localparam int             PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [3:0]     IDX_NONE = 4'hF;

    typedef struct packed {
        logic [3:0] idx;
        logic       up;
    } evt_t;

    logic [N_SW-1:0] acc, acc_up;

    // ---------------- per-switch debounce lanes ----------------
    for (genvar g = 0; g < N_SW; g++) begin : g_lane
        switch_debounce_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .raw_i   (SW_RAW[g]),
            .clean_o (SW_CLEAN[g]),
            .hist_o  (SW_HISTORY[g]),
            .rise_o  (SW_RISE[g]),
            .fall_o  (SW_FALL[g]),
            .acc_o   (acc[g]),
            .acc_up_o(acc_up[g])
        );
    end

    // ---------------- pending stage + scanner ----------------
    logic [N_SW-1:0] pend_q, pend_d;
    logic [N_SW-1:0] pdir_q, pdir_d;
    logic            ovf_q, ovf_d;
    logic            scan_hit;
    logic [3:0]      scan_idx;

    // FIFO state
    evt_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]  fcnt_q;
    logic            pop, push, can_push;
    evt_t            push_evt, head;

    // Lowest pending index: scan downwards so the last hit wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                scan_hit = 1'b1;
                scan_idx = 4'(i);
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped this cycle.
    assign pop          = (fcnt_q != '0) && EVT_READY;
    assign can_push     = (fcnt_q != FULL_CNT) || pop;
    assign push         = scan_hit && can_push;
    assign push_evt.idx = scan_idx;
    assign push_evt.up  = pdir_q[scan_idx];

    // The pushed entry is cleared before new edges are applied, so an edge
    // landing on the switch being pushed re-arms it without flagging overflow
    // (the push itself carries the old direction).
    always_comb begin
        pend_d = pend_q;
        pdir_d = pdir_q;
        ovf_d  = ovf_q;
        if (push) begin
            pend_d[scan_idx] = 1'b0;
        end
        for (int i = 0; i < N_SW; i++) begin
            if (acc[i]) begin
                if (pend_d[i]) begin
                    ovf_d = 1'b1;
                end
                pend_d[i] = 1'b1;
                pdir_d[i] = acc_up[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_q <= '0;
            pdir_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pdir_q <= pdir_d;
            ovf_q  <= ovf_d;
        end
    end

    // ---------------- event FIFO ----------------
    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once it has been written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_evt;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign EVT_VALID = (fcnt_q != '0);
    assign EVT_IDX   = EVT_VALID ? head.idx : IDX_NONE;
    assign EVT_UP    = EVT_VALID & head.up;
    assign OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_switch_debounce_event.sv
module tb_switch_debounce_event;
    localparam int N     = 10;
    localparam int SYNC  = 2;
    localparam int DB    = 8;
    localparam int CNTW  = 4;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic [N-1:0] SW_RAW;
    logic [N-1:0] SW_CLEAN, SW_HISTORY, SW_RISE, SW_FALL;
    logic         EVT_VALID, EVT_UP, EVT_READY, OVERFLOW;
    logic [3:0]   EVT_IDX;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    switch_debounce_event #(
        .N_SW(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
        .CNT_W(CNTW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SW_RAW(SW_RAW),
        .SW_CLEAN(SW_CLEAN), .SW_HISTORY(SW_HISTORY),
        .SW_RISE(SW_RISE), .SW_FALL(SW_FALL),
        .EVT_VALID(EVT_VALID), .EVT_IDX(EVT_IDX), .EVT_UP(EVT_UP),
        .EVT_READY(EVT_READY), .OVERFLOW(OVERFLOW)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Synchroniser = a plain delay queue of raw samples; debounce = "the last
    // DB samples all differ from the clean level"; pending set = two arrays;
    // FIFO = a queue of {idx, up}.
    logic [N-1:0] rawq[$];
    logic [N-1:0] win[$];
    logic [4:0]   fifo[$];
    logic [N-1:0] m_clean, m_hist, m_rise, m_fall, m_pend, m_pdir, m_s, m_acc;
    logic         m_ovf, m_all, m_pop;
    int           m_sel;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rawq.delete();
            for (int k = 0; k < SYNC; k++) rawq.push_back('0);
            win.delete();
            fifo.delete();
            m_clean = '0; m_hist = '0; m_rise = '0; m_fall = '0;
            m_pend = '0; m_pdir = '0; m_ovf = 1'b0;
        end else begin
            m_s = rawq[0];
            rawq.push_back(SW_RAW);
            rawq.delete(0);
            win.push_back(m_s);
            if (win.size() > DB) win.delete(0);
            m_acc = '0;
            if (win.size() == DB) begin
                for (int i = 0; i < N; i++) begin
                    m_all = 1'b1;
                    foreach (win[k]) if (win[k][i] == m_clean[i]) m_all = 1'b0;
                    m_acc[i] = m_all;
                end
            end
            m_pop = (fifo.size() != 0) && EVT_READY;
            m_sel = -1;
            for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_sel = i;
            if (m_pop) fifo.delete(0);
            if (m_sel >= 0 && fifo.size() < DEPTH) begin
                fifo.push_back({4'(m_sel), m_pdir[m_sel]});
                m_pend[m_sel] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_acc[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_pend[i] = 1'b1;
                    m_pdir[i] = ~m_clean[i];
                end
            end
            m_hist  = m_clean;
            m_rise  = m_acc & ~m_clean;
            m_fall  = m_acc & m_clean;
            m_clean = m_clean ^ m_acc;
        end
    end

    // ---------------- every-cycle compare ----------------
    logic       e_v, e_up;
    logic [3:0] e_idx;
    always @(negedge CLK) begin
        if (fifo.size() != 0) begin
            e_v = 1'b1; e_idx = fifo[0][4:1]; e_up = fifo[0][0];
        end else begin
            e_v = 1'b0; e_idx = 4'hF; e_up = 1'b0;
        end
        chk("clean",    32'(SW_CLEAN),   32'(m_clean));
        chk("history",  32'(SW_HISTORY), 32'(m_hist));
        chk("rise",     32'(SW_RISE),    32'(m_rise));
        chk("fall",     32'(SW_FALL),    32'(m_fall));
        chk("evt_valid",32'(EVT_VALID),  32'(e_v));
        chk("evt_idx",  32'(EVT_IDX),    32'(e_idx));
        chk("evt_up",   32'(EVT_UP),     32'(e_up));
        chk("overflow", 32'(OVERFLOW),   32'(m_ovf));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed scenarios with literal expectations ----------------
    initial begin
        int r;
        int lo;
        RESET_N = 1'b0; SW_RAW = '0; EVT_READY = 1'b0;
        tick(3);
        RESET_N = 1'b1;
        look();
        chk("rst_clean", 32'(SW_CLEAN), 0);
        chk("rst_hist",  32'(SW_HISTORY), 0);
        chk("rst_rise",  32'(SW_RISE | SW_FALL), 0);
        chk("rst_valid", 32'(EVT_VALID), 0);
        chk("rst_idx",   32'(EVT_IDX), 32'hF);
        chk("rst_up",    32'(EVT_UP | OVERFLOW), 0);

        // 1: single rise, 10-cycle latency, history and FIFO head follow
        tick(1); SW_RAW[3] = 1'b1;
        tick(9); look(); chk("t1_pre",   32'(SW_CLEAN[3]), 0);
        tick(1); look(); chk("t1_clean", 32'(SW_CLEAN[3]), 1);
        chk("t1_rise", 32'(SW_RISE), 32'h008);
        chk("t1_hist0", 32'(SW_HISTORY[3]), 0);
        tick(1); look(); chk("t1_hist1", 32'(SW_HISTORY[3]), 1);
        chk("t1_rise_off", 32'(SW_RISE[3]), 0);
        chk("t1_head", 32'({EVT_VALID, EVT_IDX, EVT_UP}), 32'({1'b1, 4'd3, 1'b1}));
        tick(1); EVT_READY = 1'b1;
        tick(1); look(); chk("t1_drained", 32'(EVT_VALID), 0);

        // 2: bounce shorter than the window, then hold
        tick(1);
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) SW_RAW[5] = ~SW_RAW[5];
            tick(1);
        end
        SW_RAW[5] = 1'b1;
        tick(9); look(); chk("t2_pre",   32'(SW_CLEAN[5]), 0);
        tick(1); look(); chk("t2_rise",  32'(SW_RISE), 32'h020);
        tick(1); look(); chk("t2_head",  32'({EVT_VALID, EVT_IDX}), 32'({1'b1, 4'd5}));
        tick(1); look(); chk("t2_single", 32'(EVT_VALID), 0);

        // 3: simultaneous edges serialise in index order
        tick(1); SW_RAW[0] = 1'b1; SW_RAW[2] = 1'b1; SW_RAW[9] = 1'b1;
        tick(10); look(); chk("t3_rise", 32'(SW_RISE), 32'h205);
        tick(1); look(); chk("t3_e0", 32'(EVT_IDX), 0);
        tick(1); look(); chk("t3_e1", 32'(EVT_IDX), 2);
        tick(1); look(); chk("t3_e2", 32'(EVT_IDX), 9);
        tick(1); look(); chk("t3_empty", 32'(EVT_VALID), 0);

        // 4: six rises against a stalled consumer
        tick(1); RESET_N = 1'b0; SW_RAW = '0; EVT_READY = 1'b0;
        tick(2); RESET_N = 1'b1;
        tick(1); SW_RAW = 10'h03F;
        tick(10); look(); chk("t4_rise", 32'(SW_RISE), 32'h03F);
        tick(6); look();
        chk("t4_head", 32'({EVT_VALID, EVT_IDX}), 32'({1'b1, 4'd0}));
        chk("t4_ovf", 32'(OVERFLOW), 0);
        tick(1); EVT_READY = 1'b1;
        for (int e = 0; e < 6; e++) begin
            look(); chk("t4_order", 32'(EVT_IDX), 32'(e));
            tick(1);
        end
        look(); chk("t4_empty", 32'({EVT_VALID, EVT_IDX}), 32'({1'b0, 4'hF}));

        // 5: overwrite while FIFO is full
        tick(1); EVT_READY = 1'b0; SW_RAW = 10'h030;
        tick(10); look(); chk("t5_fall", 32'(SW_FALL), 32'h00F);
        tick(5); SW_RAW[7] = 1'b1;
        tick(10); look(); chk("t5_rise7", 32'(SW_RISE[7]), 1);
        chk("t5_ovf0", 32'(OVERFLOW), 0);
        tick(2); SW_RAW[7] = 1'b0;
        tick(10); look(); chk("t5_fall7", 32'(SW_FALL[7]), 1);
        chk("t5_ovf1", 32'(OVERFLOW), 1);
        tick(1); EVT_READY = 1'b1;
        for (int e = 0; e < 4; e++) begin
            look(); chk("t5_drain", 32'({EVT_IDX, EVT_UP}), 32'({4'(e), 1'b0}));
            tick(1);
        end
        look(); chk("t5_ev7", 32'({EVT_VALID, EVT_IDX, EVT_UP}), 32'({1'b1, 4'd7, 1'b0}));
        tick(5); look(); chk("t5_sticky", 32'(OVERFLOW), 1);

        // 6: reset in the middle of a debounce window
        tick(1); SW_RAW[1] = 1'b1;
        tick(7); RESET_N = 1'b0;
        look();
        chk("t6_rst", 32'({SW_CLEAN, EVT_VALID, EVT_IDX, EVT_UP, OVERFLOW}),
            32'({10'h000, 1'b0, 4'hF, 1'b0, 1'b0}));
        tick(1); RESET_N = 1'b1;
        tick(9); look(); chk("t6_pre",  32'(SW_CLEAN), 0);
        tick(1); look(); chk("t6_post", 32'(SW_CLEAN), 32'h032);

        // randomized phase, checked by the model every cycle
        tick(1);
        for (int seg = 0; seg < 30; seg++) begin
            lo = int'($urandom_range(0, 1));
            if (seg == 15) begin
                RESET_N = 1'b0; tick(2); RESET_N = 1'b1;
            end
            for (int c = 0; c < 100; c++) begin
                EVT_READY = (lo != 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    r = int'($urandom_range(0, N - 1));
                    SW_RAW[r] = ~SW_RAW[r];
                end
                tick(1);
            end
        end
        EVT_READY = 1'b1;
        tick(40);
        look();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
